// File: rtl/fma16_mul_arbiter.sv
// fma16_mul_arbiter: round-robin share of one fp16 multiplier between two requesters with a registered tagged response
module fma16_mul_arbiter #(
    parameter int MUL_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [15:0]      a_x,
    input  logic [15:0]      a_y,
    input  logic             a_negp,
    input  logic [1:0]       a_roundmode,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [15:0]      b_x,
    input  logic [15:0]      b_y,
    input  logic             b_negp,
    input  logic [1:0]       b_roundmode,
    output logic [15:0]      mul_x,
    output logic [15:0]      mul_y,
    output logic             mul_negp,
    output logic [1:0]       mul_roundmode,
    input  logic [15:0]      mul_product,
    input  logic [3:0]       mul_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [15:0]      rsp_product,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       sticky_flags,
    input  logic             flags_clr,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
    state_t state, next_state;
    logic last_grant, id, grant_a, grant_b, deliver;
    logic [2:0] lat_cnt;
    // last_grant holds the id of the previous winner, so the other side wins a tie
    assign grant_a = a_valid & (~b_valid | last_grant);
    assign grant_b = b_valid & (~a_valid | ~last_grant);
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end
    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (grant_a | grant_b) ? MUL : IDLE;
            MUL:     next_state = (lat_cnt == 3'd0) ? RESP : MUL;
            RESP:    next_state = rsp_ready ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end
    // handshake outputs, only offered while idle
    always_comb begin
        a_ready = (state == IDLE) & grant_a;
        b_ready = (state == IDLE) & grant_b;
        deliver = rsp_valid & rsp_ready;
    end
    // operand capture, latency count, result capture, statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_x         <= '0;
            mul_y         <= '0;
            mul_negp      <= 1'b0;
            mul_roundmode <= '0;
            id            <= 1'b0;
            last_grant    <= 1'b1;
            lat_cnt       <= '0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_product   <= '0;
            rsp_flags     <= '0;
            sticky_flags  <= '0;
            op_count      <= '0;
        end else begin
            if (a_ready | b_ready) begin
                mul_x         <= b_ready ? b_x : a_x;
                mul_y         <= b_ready ? b_y : a_y;
                mul_negp      <= b_ready ? b_negp : a_negp;
                mul_roundmode <= b_ready ? b_roundmode : a_roundmode;
                id            <= b_ready;
                last_grant    <= b_ready;
                lat_cnt       <= 3'(MUL_LAT - 1);
            end
            if (state == MUL) begin
                if (lat_cnt != 3'd0) begin
                    lat_cnt <= lat_cnt - 3'd1;
                end else begin
                    rsp_product <= mul_product;
                    rsp_flags   <= mul_flags;
                    rsp_id      <= id;
                    rsp_valid   <= 1'b1;
                end
            end
            if (deliver) begin
                rsp_valid <= 1'b0;
                op_count  <= op_count + CNT_W'(1);
            end
            if (deliver | flags_clr)
                sticky_flags <= (flags_clr ? 4'h0 : sticky_flags) | (deliver ? rsp_flags : 4'h0);
        end
    end
endmodule

// File: tb/tb_fma16_mul_arbiter.sv
// tb_fma16_mul_arbiter: randomized and directed checks of the arbiter against a transaction-level model
module tb_fma16_mul_arbiter;
    localparam int LAT = 1;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic a_valid = 0, a_ready, a_negp = 0, b_valid = 0, b_ready, b_negp = 0;
    logic [15:0] a_x = 0, a_y = 0, b_x = 0, b_y = 0;
    logic [1:0] a_roundmode = 0, b_roundmode = 0, mul_roundmode;
    logic [15:0] mul_x, mul_y, mul_product, rsp_product, op_count;
    logic mul_negp, rsp_valid, rsp_ready = 0, rsp_id, flags_clr = 0;
    logic [3:0] mul_flags, rsp_flags, sticky_flags;

    logic t_a_valid = 0, t_a_ready, t_b_ready, t_mul_negp, t_rsp_valid, t_rsp_id;
    logic [15:0] t_a_x = 0, t_a_y = 0, t_mul_x, t_mul_y, t_mul_product, t_rsp_product, t_op_count;
    logic [15:0] t_glitch = 0;
    logic [1:0] t_mul_rm;
    logic [3:0] t_mul_flags, t_rsp_flags, t_sticky;

    int checks = 0, errors = 0;
    logic [16:0] seen[$];

    // stand-in multiplier: truncating fp16 multiply of normal numbers
    function automatic logic [15:0] fmul(input logic [15:0] x, y, input logic n);
        logic [21:0] m;
        int e;
        m = {1'b1, x[9:0]} * {1'b1, y[9:0]};
        e = int'(x[14:10]) + int'(y[14:10]) - 15;
        if (m[21]) return {x[15] ^ y[15] ^ n, 5'(e + 1), m[20:11]};
        return {x[15] ^ y[15] ^ n, 5'(e), m[19:10]};
    endfunction
    function automatic logic [3:0] fflags(input logic [15:0] x, y);
        return x[3:0] ^ y[3:0];
    endfunction
    function automatic logic [15:0] rand_fp();
        return {1'($urandom % 2), 5'($urandom_range(20, 10)), 10'($urandom % 1024)};
    endfunction

    assign mul_product   = fmul(mul_x, mul_y, mul_negp);
    assign mul_flags     = fflags(mul_x, mul_y);
    assign t_mul_product = fmul(t_mul_x, t_mul_y, t_mul_negp) ^ t_glitch;
    assign t_mul_flags   = fflags(t_mul_x, t_mul_y);

    fma16_mul_arbiter #(.MUL_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_negp(a_negp), .a_roundmode(a_roundmode),
        .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_negp(b_negp), .b_roundmode(b_roundmode),
        .mul_x(mul_x), .mul_y(mul_y), .mul_negp(mul_negp), .mul_roundmode(mul_roundmode),
        .mul_product(mul_product), .mul_flags(mul_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .rsp_flags(rsp_flags), .sticky_flags(sticky_flags), .flags_clr(flags_clr), .op_count(op_count)
    );

    fma16_mul_arbiter #(.MUL_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .a_valid(t_a_valid), .a_ready(t_a_ready), .a_x(t_a_x), .a_y(t_a_y), .a_negp(1'b0), .a_roundmode(2'd0),
        .b_valid(1'b0), .b_ready(t_b_ready), .b_x(16'h0), .b_y(16'h0), .b_negp(1'b0), .b_roundmode(2'd0),
        .mul_x(t_mul_x), .mul_y(t_mul_y), .mul_negp(t_mul_negp), .mul_roundmode(t_mul_rm),
        .mul_product(t_mul_product), .mul_flags(t_mul_flags),
        .rsp_valid(t_rsp_valid), .rsp_ready(1'b1), .rsp_id(t_rsp_id), .rsp_product(t_rsp_product),
        .rsp_flags(t_rsp_flags), .sticky_flags(t_sticky), .flags_clr(1'b0), .op_count(t_op_count)
    );

    // transaction-level model of the main instance
    bit m_busy, m_rv, m_last;
    int m_age;
    logic [15:0] m_x, m_y, m_prod, m_count;
    logic m_neg, m_id, m_rid;
    logic [1:0] m_rm;
    logic [3:0] m_flags, m_sticky;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rv = 0; m_last = 1; m_age = 0;
        m_x = 0; m_y = 0; m_prod = 0; m_count = 0;
        m_neg = 0; m_id = 0; m_rid = 0; m_rm = 0; m_flags = 0; m_sticky = 0;
    endtask

    function automatic int want();
        if (a_valid && b_valid) return m_last ? 0 : 1;
        if (a_valid) return 0;
        if (b_valid) return 1;
        return -1;
    endfunction

    // called at a falling edge with inputs already driven; checks, then advances one clock
    task automatic step();
        int w;
        bit dv;
        #1;
        w = m_busy ? -1 : want();
        check("a_ready", a_ready, w == 0);
        check("b_ready", b_ready, w == 1);
        check("rsp", {rsp_valid, rsp_id, rsp_flags, rsp_product}, {m_rv, m_rid, m_flags, m_prod});
        check("mul_in", {mul_negp, mul_roundmode, mul_x, mul_y}, {m_neg, m_rm, m_x, m_y});
        check("sticky", sticky_flags, m_sticky);
        check("op_count", op_count, m_count);
        if (rsp_valid && rsp_ready) seen.push_back({rsp_id, rsp_product});
        dv = m_rv && rsp_ready;
        @(posedge clk);
        if (!m_busy) begin
            if (w >= 0) begin
                m_busy = 1; m_age = 0; m_id = w[0]; m_last = w[0];
                {m_neg, m_rm, m_x, m_y} = w == 1 ? {b_negp, b_roundmode, b_x, b_y} : {a_negp, a_roundmode, a_x, a_y};
            end
        end else if (!m_rv) begin
            m_age++;
            if (m_age == LAT) begin
                m_rv = 1; m_rid = m_id; m_prod = fmul(m_x, m_y, m_neg); m_flags = fflags(m_x, m_y);
            end
        end else if (dv) begin
            m_rv = 0; m_busy = 0; m_count++;
        end
        if (dv) m_sticky = (flags_clr ? 4'h0 : m_sticky) | m_flags;
        else if (flags_clr) m_sticky = 0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 0; a_valid = 0; b_valid = 0; rsp_ready = 0; flags_clr = 0; t_a_valid = 0;
        #1;
        check("rst_out", {rsp_valid, rsp_id, rsp_flags, rsp_product, sticky_flags, op_count}, 64'h0);
        check("rst_mul", {mul_negp, mul_roundmode, mul_x, mul_y}, 64'h0);
        check("rst_ready", {a_ready, b_ready}, 64'h0);
        check("rst_dut3", {t_rsp_valid, t_op_count, t_mul_x}, 64'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic op(input bit isb, input logic [15:0] x, y, input bit clr_d);
        a_valid = !isb; b_valid = isb; a_x = x; a_y = y; b_x = x; b_y = y;
        rsp_ready = 0; flags_clr = 0;
        step();
        a_valid = 0; b_valid = 0;
        repeat (LAT) step();
        rsp_ready = 1; flags_clr = clr_d;
        step();
        rsp_ready = 0; flags_clr = 0;
        step();
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // three-cycle latency instance: timing, operand hold, late capture
        t_a_valid = 1; t_a_x = 16'h3C00; t_a_y = 16'h4000;
        #1 check("l3_ready", t_a_ready, 1);
        @(posedge clk);
        @(negedge clk);
        t_a_valid = 0; t_glitch = 16'hFFFF;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check("l3_hold", {t_mul_x, t_mul_y}, {16'h3C00, 16'h4000});
            check("l3_wait", t_rsp_valid, 0);
            check("l3_noready", t_a_ready, 0);
            if (k == 3) t_glitch = 0;
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check("l3_rsp", {t_rsp_valid, t_rsp_id, t_rsp_product}, {1'b1, 1'b0, 16'h4000});
        @(negedge clk);
        check("l3_cnt", {t_rsp_valid, t_op_count}, {1'b0, 16'd1});

        // single A op 1.0 x 2.0
        seen.delete();
        op(0, 16'h3C00, 16'h4000, 0);
        check("single_n", seen.size(), 1);
        if (seen.size() > 0) check("single_rsp", seen[0], {1'b0, 16'h4000});
        check("single_cnt", op_count, 1);

        // alternation from reset
        do_reset();
        seen.delete();
        a_valid = 1; b_valid = 1; a_x = 16'h3C00; a_y = 16'h4000; b_x = 16'h4000; b_y = 16'h4200; rsp_ready = 1;
        repeat (12) step();
        check("alt_n", seen.size(), 4);
        for (int i = 0; i < seen.size(); i++)
            check("alt_seq", seen[i], (i % 2) ? {1'b1, 16'h4600} : {1'b0, 16'h4000});

        // backpressure with both requesters waiting
        a_valid = 1; b_valid = 0; rsp_ready = 0;
        step();
        b_valid = 1;
        repeat (1 + 5) step();
        rsp_ready = 1;
        step();
        a_valid = 0; b_valid = 0; rsp_ready = 0;
        check("bp_cnt", op_count, 5);

        // sticky flags
        flags_clr = 1;
        step();
        flags_clr = 0;
        op(0, 16'h3C01, 16'h3C00, 0);
        op(1, 16'h3C04, 16'h3C00, 0);
        check("sticky_or", sticky_flags, 4'h5);
        op(0, 16'h3C02, 16'h3C00, 1);
        check("sticky_clr", sticky_flags, 4'h2);

        // reset while in MUL
        a_valid = 1; a_x = 16'h4000; a_y = 16'h4000;
        step();
        do_reset();
        repeat (3) step();
        a_valid = 1; b_valid = 1;
        #1 check("post_rst_grant", {a_ready, b_ready}, 2'b10);
        step();
        a_valid = 0; b_valid = 0;
        repeat (4) step();

        // randomized traffic
        repeat (400) begin
            a_valid = 1'($urandom % 2); b_valid = 1'($urandom % 2);
            a_x = rand_fp(); a_y = rand_fp(); b_x = rand_fp(); b_y = rand_fp();
            a_negp = 1'($urandom % 2); b_negp = 1'($urandom % 2);
            a_roundmode = 2'($urandom % 4); b_roundmode = 2'($urandom % 4);
            rsp_ready = ($urandom % 4) != 0; flags_clr = ($urandom % 8) == 0;
            step();
        end
        a_valid = 0; b_valid = 0; rsp_ready = 1; flags_clr = 0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
